// File: rtl/memory_unit.sv
// memory_unit: ARM32 memory-stage controller (LDR/STR decode, req/ack data-memory handshake, upstream stall).
// Optional `MEM_TIMEOUT_EN: abort an access after TIMEOUT_CYCLES without ack and raise sticky mem_fault.
module memory_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr_in,
    input  logic        flush_in,
    input  logic        cond_pass,
    input  logic        mem_ack,
    output logic        stall_out,
    output logic [3:0]  rd,
    output logic        rd_valid,
    output logic        mem_req,
    output logic        mem_we,
    output logic        sel_addr,
    output logic        en_wb_base,
    output logic        sel_load,
    output logic        en_C,
    output logic        mem_fault,
    output logic [31:0] instr_output
);
    localparam logic [31:0] BUBBLE = 32'hF000_0000;

    typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

    state_t      r_state;
    logic [31:0] r_instr;
    logic        w_access;
    logic        w_stall;
    logic        w_squash;
    logic        w_mem;
    logic        w_alu;
    logic        w_bl;
    logic        w_load;
    logic        w_next_mem;
    logic        w_abort;

    // opcode[6:0] is instr[27:21]; single data transfers are recognised on bits 27:26 = 2'b01
    function automatic logic f_is_mem(input logic [31:0] i);
        return (i[27:26] == 2'b01) || (i[27:24] == 4'b1000);
    endfunction

    assign w_access   = (r_state == ACCESS);
    assign w_stall    = w_access & ~mem_ack;
    assign w_squash   = (r_instr[31:28] == 4'hF) | ~cond_pass;
    assign w_mem      = f_is_mem(r_instr);
    assign w_alu      = ~w_mem & ~r_instr[27] & (r_instr[26:25] != 2'b10);
    assign w_bl       = (r_instr[27:24] == 4'b1011);
    assign w_load     = r_instr[20];
    assign w_next_mem = ~flush_in & f_is_mem(instr_in) & (instr_in[31:28] != 4'hF);

`ifdef MEM_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_fault;

    assign w_abort = w_stall & (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_fault <= 1'b0;
        end else if (w_abort) begin
            r_cnt   <= '0;
            r_fault <= 1'b1;
        end else if (w_stall) begin
            r_cnt   <= r_cnt + 1'b1;
        end else begin
            r_cnt   <= '0;
        end
    end

    assign mem_fault = r_fault;
`else
    assign w_abort   = 1'b0;
    assign mem_fault = 1'b0;
`endif

    // An ack (or IDLE) frees the stage: the next instruction is latched and decides whether ACCESS continues.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_instr <= BUBBLE;
            r_state <= IDLE;
        end else if (w_abort) begin
            r_instr <= BUBBLE;
            r_state <= IDLE;
        end else if (!w_stall) begin
            r_instr <= flush_in ? BUBBLE : instr_in;
            r_state <= w_next_mem ? ACCESS : IDLE;
        end
    end

    assign mem_req      = w_access;
    assign stall_out    = w_stall;
    assign mem_we       = w_access & ~w_load;
    assign sel_addr     = w_access & r_instr[24];
    assign en_wb_base   = w_access & ~w_squash & (r_instr[21] | ~r_instr[24]);
    assign sel_load     = w_access & w_load & ~w_squash;
    assign en_C         = (w_alu | w_mem) & ~w_squash;
    assign rd_valid     = (w_alu | w_bl) & ~w_squash;
    assign rd           = !rd_valid ? 4'hF : (w_bl ? 4'hE : r_instr[15:12]);
    assign instr_output = w_stall ? BUBBLE : r_instr;

endmodule

// File: tb/tb_memory_unit.sv
// tb_memory_unit: directed scenarios followed by random instruction/ack traffic, checked against
// a transaction-level model of the memory stage.
module tb_memory_unit;
    localparam int unsigned TIMEOUT = 16;
    localparam logic [31:0] BUBBLE  = 32'hF000_0000;
    localparam logic [31:0] ADD_R3  = 32'hE081_3002;
    localparam logic [31:0] LDR_R1  = 32'hE592_1004;
    localparam logic [31:0] STR_PI  = 32'hE482_1004;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] instr_in;
    logic        flush_in;
    logic        cond_pass;
    logic        mem_ack;
    logic        stall_out;
    logic [3:0]  rd;
    logic        rd_valid;
    logic        mem_req;
    logic        mem_we;
    logic        sel_addr;
    logic        en_wb_base;
    logic        sel_load;
    logic        en_C;
    logic        mem_fault;
    logic [31:0] instr_output;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    // Model: the instruction held in the stage, whether it still owes a memory access, fault flag.
    logic [31:0] m_instr;
    logic        m_busy;
    logic        m_fault;
`ifdef MEM_TIMEOUT_EN
    int unsigned m_wait;
`endif

    memory_unit #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .instr_in     (instr_in),
        .flush_in     (flush_in),
        .cond_pass    (cond_pass),
        .mem_ack      (mem_ack),
        .stall_out    (stall_out),
        .rd           (rd),
        .rd_valid     (rd_valid),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .sel_addr     (sel_addr),
        .en_wb_base   (en_wb_base),
        .sel_load     (sel_load),
        .en_C         (en_C),
        .mem_fault    (mem_fault),
        .instr_output (instr_output)
    );

    always #5 clk = ~clk;

    function automatic logic is_mem_op(input logic [31:0] i);
        return (i[27:26] == 2'b01) || (i[27:24] == 4'b1000);
    endfunction

    function automatic logic is_alu_op(input logic [31:0] i);
        return i[27:26] == 2'b00;
    endfunction

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h required %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %b required %b", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_instr = BUBBLE;
        m_busy  = 1'b0;
        m_fault = 1'b0;
`ifdef MEM_TIMEOUT_EN
        m_wait  = 0;
`endif
    endtask

    task automatic check_all();
        logic sq, waiting, mem, alu, rv;
        sq      = (m_instr[31:28] == 4'hF) || !cond_pass;
        waiting = m_busy && !mem_ack;
        mem     = is_mem_op(m_instr);
        alu     = is_alu_op(m_instr);
        rv      = alu && !sq;
        chk1("stall_out", stall_out, waiting);
        chk1("mem_req", mem_req, m_busy);
        chk1("mem_we", mem_we, m_busy && !m_instr[20]);
        chk1("sel_addr", sel_addr, m_busy && m_instr[24]);
        chk1("en_wb_base", en_wb_base, m_busy && !sq && (m_instr[21] || !m_instr[24]));
        chk1("sel_load", sel_load, mem && m_instr[20] && !sq);
        chk1("en_C", en_C, (alu || mem) && !sq);
        chk1("rd_valid", rd_valid, rv);
        chk32("rd", 32'(rd), rv ? 32'(m_instr[15:12]) : 32'hF);
        chk1("mem_fault", mem_fault, m_fault);
        chk32("instr_output", instr_output, waiting ? BUBBLE : m_instr);
    endtask

    task automatic model_step();
        if (m_busy && !mem_ack) begin
`ifdef MEM_TIMEOUT_EN
            m_wait++;
            if (m_wait == TIMEOUT) begin
                m_busy  = 1'b0;
                m_fault = 1'b1;
                m_instr = BUBBLE;
                m_wait  = 0;
            end
`endif
        end else begin
            m_instr = flush_in ? BUBBLE : instr_in;
            m_busy  = is_mem_op(m_instr) && (m_instr[31:28] != 4'hF);
`ifdef MEM_TIMEOUT_EN
            m_wait  = 0;
`endif
        end
    endtask

    task automatic cycle(input logic [31:0] ins, input logic fl, input logic cp, input logic ack);
        @(negedge clk);
        rst_n     = 1'b1;
        instr_in  = ins;
        flush_in  = fl;
        cond_pass = cp;
        mem_ack   = ack;
        #1;
        check_all();
        model_step();
    endtask

    initial begin
        int unsigned n_req, n_st;
        logic [31:0] ins;
        logic [3:0]  cond;

        rst_n = 1'b0; instr_in = BUBBLE; flush_in = 1'b0; cond_pass = 1'b1; mem_ack = 1'b0;
        model_reset();
        #12;
        chk32("reset_rd", 32'(rd), 32'hF);
        chk1("reset_mem_req", mem_req, 1'b0);
        chk1("reset_stall", stall_out, 1'b0);
        chk1("reset_en_C", en_C, 1'b0);
        chk32("reset_instr_output", instr_output, BUBBLE);

        // Asynchronous reset in the middle of an access
        cycle(LDR_R1, 1'b0, 1'b1, 1'b0);
        cycle(BUBBLE, 1'b0, 1'b1, 1'b0);
        chk1("t1_mem_req_before", mem_req, 1'b1);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        chk1("t1_mem_req", mem_req, 1'b0);
        chk1("t1_stall", stall_out, 1'b0);
        chk32("t1_rd", 32'(rd), 32'hF);
        chk32("t1_instr_output", instr_output, BUBBLE);

        // ALU result forwarding
        cycle(ADD_R3, 1'b0, 1'b1, 1'b0);
        cycle(BUBBLE, 1'b0, 1'b1, 1'b0);
        chk32("t2_rd", 32'(rd), 32'h3);
        chk1("t2_rd_valid", rd_valid, 1'b1);
        chk1("t2_en_C", en_C, 1'b1);
        chk1("t2_mem_req", mem_req, 1'b0);

        // Load acknowledged on the third ACCESS cycle
        cycle(LDR_R1, 1'b0, 1'b1, 1'b0);
        n_req = 0; n_st = 0;
        for (int k = 0; k < 4; k++) begin
            cycle(BUBBLE, 1'b0, 1'b1, k == 2);
            if (mem_req) n_req++;
            if (stall_out) n_st++;
            if (k == 0) begin
                chk1("t3_mem_we", mem_we, 1'b0);
                chk1("t3_sel_load", sel_load, 1'b1);
                chk1("t3_rd_valid", rd_valid, 1'b0);
            end
        end
        chk32("t3_req_cycles", n_req, 3);
        chk32("t3_stall_cycles", n_st, 2);

        // Post-index store with zero-wait ack
        cycle(STR_PI, 1'b0, 1'b1, 1'b0);
        cycle(BUBBLE, 1'b0, 1'b1, 1'b1);
        chk1("t4_mem_req", mem_req, 1'b1);
        chk1("t4_mem_we", mem_we, 1'b1);
        chk1("t4_sel_addr", sel_addr, 1'b0);
        chk1("t4_en_wb_base", en_wb_base, 1'b1);
        chk1("t4_stall", stall_out, 1'b0);
        cycle(BUBBLE, 1'b0, 1'b1, 1'b0);
        chk1("t4_req_done", mem_req, 1'b0);

        // Back-to-back load/store; flush during the load stall is ignored
        cycle(LDR_R1, 1'b0, 1'b1, 1'b0);
        cycle(STR_PI, 1'b1, 1'b1, 1'b0);
        chk1("t5_stall", stall_out, 1'b1);
        cycle(STR_PI, 1'b0, 1'b1, 1'b1);
        cycle(BUBBLE, 1'b0, 1'b1, 1'b0);
        chk1("t5_str_req", mem_req, 1'b1);
        chk1("t5_str_we", mem_we, 1'b1);
        cycle(BUBBLE, 1'b0, 1'b1, 1'b1);
        cycle(BUBBLE, 1'b0, 1'b1, 1'b0);

        // Access that is never acknowledged
        cycle(LDR_R1, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 20; k++) cycle(BUBBLE, 1'b0, 1'b1, 1'b0);
`ifdef MEM_TIMEOUT_EN
        chk1("t6_fault", mem_fault, 1'b1);
        chk1("t6_stall", stall_out, 1'b0);
        chk1("t6_mem_req", mem_req, 1'b0);
`else
        chk1("t6_fault", mem_fault, 1'b0);
        chk1("t6_still_waiting", stall_out, 1'b1);
`endif
        cycle(BUBBLE, 1'b0, 1'b1, 1'b1);

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            cond = 4'($urandom_range(0, 14));
            case ($urandom_range(0, 9))
                0, 1, 2, 3: ins = {cond, 2'b00, 26'($urandom)};
                4, 5, 6:    ins = {cond, 2'b01, 26'($urandom)};
                7:          ins = BUBBLE;
                8:          ins = {4'hF, 1'b0, 27'($urandom)};
                default:    ins = {cond, 4'b1000, 24'($urandom)};
            endcase
            cycle(ins, $urandom_range(0, 7) == 0, $urandom_range(0, 4) != 0, $urandom_range(0, 1) == 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
